// File: rtl/stopwatch_lap_controller.sv
// Run/lap sequencer for the 4-digit BCD stopwatch: turns command pulses and the 1 ms tick into
// counter strobes, keeps a small lap buffer and picks the value shown on the display.
//
// state  | meaning
// IDLE   | cleared, waiting for start
// RUN    | counting, ticks forwarded to the counter, laps captured
// PAUSE  | count frozen, start resumes, recall browses laps
// RECALL | showing stored lap idx on the display
module stopwatch_lap_controller #(
    parameter int LAP_DEPTH   = 4,
    parameter int HOLD_MS     = 2000,
    parameter int STOP_AT_MAX = 1
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               tick_1ms_i,
    input  logic                               cmd_start_i,
    input  logic                               cmd_stop_i,
    input  logic                               cmd_lap_i,
    input  logic                               cmd_recall_i,
    input  logic                               cmd_clear_i,
    input  logic [15:0]                        count_value_i,
    output logic                               cnt_enable_o,
    output logic                               cnt_clear_o,
    output logic [15:0]                        display_bcd_o,
    output logic [1:0]                         display_src_o,
    output logic [$clog2(LAP_DEPTH+1)-1:0]     lap_count_o,
    output logic                               lap_full_o,
    output logic                               lap_drop_o,
    output logic                               overflow_o
);

    localparam int CW = $clog2(LAP_DEPTH + 1);
    localparam int IW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
    localparam int HW = $clog2(HOLD_MS + 1);
    localparam logic [15:0]   BCD_MAX     = 16'h9999;
    localparam logic [CW-1:0] LAP_DEPTH_C = CW'(LAP_DEPTH);
    localparam logic [HW-1:0] HOLD_LOAD   = HW'(HOLD_MS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_RECALL = 2'd3
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   lap_count_q;
    logic [IW-1:0]   idx_q;
    logic [HW-1:0]   hold_cnt_q;
    logic [15:0]     hold_val_q;
    logic            overflow_q;
    logic            lap_drop_q;
    logic            cnt_clear_q;
    logic [15:0]     lap_mem [LAP_DEPTH];

    logic at_max;
    logic sat;
    logic lap_full;
    logic do_stop;
    logic do_start;
    logic do_lap;
    logic do_recall;
    logic ovf_tick;
    logic leave_run;
    logic lap_write;
    logic recall_last;

    // Command decode: clear beats everything, and a command only counts when it applies in
    // the current state, so a lower-priority command can act when a higher one is ignored.
    always_comb begin
        at_max      = (count_value_i == BCD_MAX);
        sat         = (STOP_AT_MAX != 0) && at_max;
        lap_full    = (lap_count_q == LAP_DEPTH_C);
        do_stop     = !cmd_clear_i && cmd_stop_i && (state_q == ST_RUN);
        do_start    = !cmd_clear_i && cmd_start_i &&
                      ((state_q == ST_IDLE) ||
                       (((state_q == ST_PAUSE) || (state_q == ST_RECALL)) && !overflow_q));
        do_lap      = !cmd_clear_i && !cmd_stop_i && cmd_lap_i && (state_q == ST_RUN);
        do_recall   = !cmd_clear_i && !do_start && cmd_recall_i &&
                      (((state_q == ST_PAUSE) && (lap_count_q != '0)) || (state_q == ST_RECALL));
        ovf_tick    = !cmd_clear_i && (state_q == ST_RUN) && tick_1ms_i && at_max;
        leave_run   = do_stop || (ovf_tick && (STOP_AT_MAX != 0));
        lap_write   = do_lap && !lap_full;
        recall_last = ((CW'(idx_q) + CW'(1)) == lap_count_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            lap_count_q <= '0;
            idx_q       <= '0;
            hold_cnt_q  <= '0;
            hold_val_q  <= '0;
            overflow_q  <= 1'b0;
            lap_drop_q  <= 1'b0;
            cnt_clear_q <= 1'b0;
        end else begin
            cnt_clear_q <= cmd_clear_i;
            lap_drop_q  <= do_lap && lap_full;
            if (cmd_clear_i) begin
                state_q     <= ST_IDLE;
                lap_count_q <= '0;
                idx_q       <= '0;
                hold_cnt_q  <= '0;
                overflow_q  <= 1'b0;
            end else begin
                if (ovf_tick) begin
                    overflow_q <= 1'b1;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (do_start) begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (lap_write) begin
                            lap_count_q <= lap_count_q + CW'(1);
                            hold_val_q  <= count_value_i;
                        end
                        // The split hold only lives while running.
                        if (leave_run) begin
                            state_q    <= ST_PAUSE;
                            hold_cnt_q <= '0;
                        end else if (lap_write) begin
                            hold_cnt_q <= HOLD_LOAD;
                        end else if (tick_1ms_i && (hold_cnt_q != '0)) begin
                            hold_cnt_q <= hold_cnt_q - HW'(1);
                        end
                    end
                    ST_PAUSE: begin
                        if (do_start) begin
                            state_q <= ST_RUN;
                        end else if (do_recall) begin
                            state_q <= ST_RECALL;
                            idx_q   <= '0;
                        end
                    end
                    ST_RECALL: begin
                        if (do_start) begin
                            state_q <= ST_RUN;
                        end else if (do_recall) begin
                            if (recall_last) begin
                                state_q <= ST_PAUSE;
                            end else begin
                                idx_q <= idx_q + IW'(1);
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Lap storage is not reset; entries past lap_count are stale by design.
    always_ff @(posedge clk_i) begin
        if (!reset_i && lap_write) begin
            lap_mem[lap_count_q[IW-1:0]] <= count_value_i;
        end
    end

    always_comb begin
        display_bcd_o = count_value_i;
        display_src_o = 2'd0;
        if (!reset_i) begin
            if (state_q == ST_RECALL) begin
                display_bcd_o = lap_mem[idx_q];
                display_src_o = 2'd2;
            end else if ((state_q == ST_RUN) && (hold_cnt_q != '0)) begin
                display_bcd_o = hold_val_q;
                display_src_o = 2'd1;
            end
        end
    end

    assign cnt_enable_o = !reset_i && !cmd_clear_i && (state_q == ST_RUN) && tick_1ms_i && !sat;
    assign cnt_clear_o  = cnt_clear_q;
    assign lap_count_o  = lap_count_q;
    assign lap_full_o   = lap_full;
    assign lap_drop_o   = lap_drop_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_stopwatch_lap_controller.sv
// Directed bench for the stopwatch run/lap sequencer with default parameters
// (LAP_DEPTH=4, HOLD_MS=2000, STOP_AT_MAX=1).
module tb_stopwatch_lap_controller;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        tick_1ms_i;
    logic        cmd_start_i;
    logic        cmd_stop_i;
    logic        cmd_lap_i;
    logic        cmd_recall_i;
    logic        cmd_clear_i;
    logic [15:0] count_value_i;
    logic        cnt_enable_o;
    logic        cnt_clear_o;
    logic [15:0] display_bcd_o;
    logic [1:0]  display_src_o;
    logic [2:0]  lap_count_o;
    logic        lap_full_o;
    logic        lap_drop_o;
    logic        overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_lap_controller dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .tick_1ms_i    (tick_1ms_i),
        .cmd_start_i   (cmd_start_i),
        .cmd_stop_i    (cmd_stop_i),
        .cmd_lap_i     (cmd_lap_i),
        .cmd_recall_i  (cmd_recall_i),
        .cmd_clear_i   (cmd_clear_i),
        .count_value_i (count_value_i),
        .cnt_enable_o  (cnt_enable_o),
        .cnt_clear_o   (cnt_clear_o),
        .display_bcd_o (display_bcd_o),
        .display_src_o (display_src_o),
        .lap_count_o   (lap_count_o),
        .lap_full_o    (lap_full_o),
        .lap_drop_o    (lap_drop_o),
        .overflow_o    (overflow_o)
    );

    always #5 clk = ~clk;

    // One clock of stimulus: apply pulses, sample cnt_enable before the edge, release after it.
    task automatic step(input logic t, input logic s, input logic p, input logic l,
                        input logic r, input logic c, output logic en);
        tick_1ms_i   = t;
        cmd_start_i  = s;
        cmd_stop_i   = p;
        cmd_lap_i    = l;
        cmd_recall_i = r;
        cmd_clear_i  = c;
        #1;
        en = cnt_enable_o;
        @(posedge clk);
        #1;
        tick_1ms_i   = 1'b0;
        cmd_start_i  = 1'b0;
        cmd_stop_i   = 1'b0;
        cmd_lap_i    = 1'b0;
        cmd_recall_i = 1'b0;
        cmd_clear_i  = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; tick_1ms_i = 1'b1; cmd_start_i = 1'b1; cmd_stop_i = 1'b0;
        cmd_lap_i = 1'b0; cmd_recall_i = 1'b0; cmd_clear_i = 1'b0; count_value_i = 16'h0000;
        @(posedge clk); #1; @(posedge clk); #1;
        n_checks++; if (cnt_enable_o !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_enable: got %0b expected 0", cnt_enable_o); end
        n_checks++; if (display_src_o !== 2'd0) begin n_fail++; $display("FAIL reset_display_src: got %0d expected 0", display_src_o); end
        reset_i = 1'b0; tick_1ms_i = 1'b0; cmd_start_i = 1'b0;
        #1;
        n_checks++; if (dut.state_q !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dut.state_q); end
        n_checks++; if (lap_count_o !== 3'd0) begin n_fail++; $display("FAIL reset_lap_count: got %0d expected 0", lap_count_o); end
        n_checks++; if ({overflow_o, lap_drop_o, cnt_clear_o, lap_full_o} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {overflow_o, lap_drop_o, cnt_clear_o, lap_full_o}); end
        @(posedge clk); #1;
    endtask

    task automatic test_run_stop();
        logic en;
        int   en_cnt = 0;
        count_value_i = 16'h0000;
        step(1, 1, 0, 0, 0, 0, en);
        n_checks++; if (en !== 1'b0) begin n_fail++; $display("FAIL start_tick_forwarded: got %0b expected 0", en); end
        for (int i = 0; i < 24; i++) begin step(1, 0, 0, 0, 0, 0, en); if (en) en_cnt++; end
        step(1, 0, 1, 0, 0, 0, en); if (en) en_cnt++;
        for (int i = 0; i < 10; i++) begin step(1, 0, 0, 0, 0, 0, en); if (en) en_cnt++; end
        n_checks++; if (en_cnt !== 25) begin n_fail++; $display("FAIL run_stop_enables: got %0d expected 25", en_cnt); end
        n_checks++; if (dut.state_q !== 2'd2) begin n_fail++; $display("FAIL run_stop_state: got %0d expected 2", dut.state_q); end
    endtask

    task automatic test_lap_hold();
        logic en;
        step(0, 0, 0, 0, 0, 1, en);
        n_checks++; if (cnt_clear_o !== 1'b1) begin n_fail++; $display("FAIL clear_strobe: got %0b expected 1", cnt_clear_o); end
        n_checks++; if (dut.state_q !== 2'd0) begin n_fail++; $display("FAIL clear_state: got %0d expected 0", dut.state_q); end
        step(0, 1, 0, 0, 0, 0, en);
        n_checks++; if (cnt_clear_o !== 1'b0) begin n_fail++; $display("FAIL clear_strobe_len: got %0b expected 0", cnt_clear_o); end
        count_value_i = 16'h0123;
        step(0, 0, 0, 1, 0, 0, en);
        count_value_i = 16'h0500;
        #1;
        n_checks++; if (lap_count_o !== 3'd1) begin n_fail++; $display("FAIL lap_count_one: got %0d expected 1", lap_count_o); end
        n_checks++; if ({display_src_o, display_bcd_o} !== {2'd1, 16'h0123}) begin n_fail++; $display("FAIL hold_start: got src %0d bcd %h expected src 1 bcd 0123", display_src_o, display_bcd_o); end
        for (int i = 0; i < 1999; i++) step(1, 0, 0, 0, 0, 0, en);
        n_checks++; if ({display_src_o, display_bcd_o} !== {2'd1, 16'h0123}) begin n_fail++; $display("FAIL hold_last_tick: got src %0d bcd %h expected src 1 bcd 0123", display_src_o, display_bcd_o); end
        step(1, 0, 0, 0, 0, 0, en);
        n_checks++; if ({display_src_o, display_bcd_o} !== {2'd0, 16'h0500}) begin n_fail++; $display("FAIL hold_expired: got src %0d bcd %h expected src 0 bcd 0500", display_src_o, display_bcd_o); end
    endtask

    task automatic test_lap_full();
        logic        en;
        logic [15:0] vals [4] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        step(0, 0, 0, 0, 0, 1, en);
        step(0, 1, 0, 0, 0, 0, en);
        for (int i = 0; i < 4; i++) begin count_value_i = vals[i]; step(0, 0, 0, 1, 0, 0, en); end
        n_checks++; if ({lap_count_o, lap_full_o, lap_drop_o} !== {3'd4, 1'b1, 1'b0}) begin n_fail++; $display("FAIL lap_fill: got count %0d full %0b drop %0b expected 4 1 0", lap_count_o, lap_full_o, lap_drop_o); end
        count_value_i = 16'h0505;
        step(0, 0, 0, 1, 0, 0, en);
        n_checks++; if ({lap_count_o, lap_drop_o} !== {3'd4, 1'b1}) begin n_fail++; $display("FAIL lap_drop_pulse: got count %0d drop %0b expected 4 1", lap_count_o, lap_drop_o); end
        step(0, 0, 1, 0, 0, 0, en);
        n_checks++; if (lap_drop_o !== 1'b0) begin n_fail++; $display("FAIL lap_drop_len: got %0b expected 0", lap_drop_o); end
        count_value_i = 16'h0777;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 0, en);
            n_checks++; if ({display_src_o, display_bcd_o} !== {2'd2, vals[i]}) begin n_fail++; $display("FAIL lap_mem_entry%0d: got src %0d bcd %h expected src 2 bcd %h", i, display_src_o, display_bcd_o, vals[i]); end
        end
        step(0, 0, 0, 0, 1, 0, en);
        n_checks++; if ({dut.state_q, display_src_o, display_bcd_o} !== {2'd2, 2'd0, 16'h0777}) begin n_fail++; $display("FAIL recall_wrap: got state %0d src %0d bcd %h expected 2 0 0777", dut.state_q, display_src_o, display_bcd_o); end
    endtask

    task automatic test_recall();
        logic en;
        step(0, 0, 0, 0, 0, 1, en);
        step(0, 1, 0, 0, 0, 0, en);
        count_value_i = 16'h0011; step(0, 0, 0, 1, 0, 0, en);
        count_value_i = 16'h0022; step(0, 0, 0, 1, 0, 0, en);
        step(0, 0, 1, 0, 0, 0, en);
        count_value_i = 16'h0777;
        step(0, 0, 0, 0, 1, 0, en);
        n_checks++; if ({display_src_o, display_bcd_o} !== {2'd2, 16'h0011}) begin n_fail++; $display("FAIL recall_first: got src %0d bcd %h expected src 2 bcd 0011", display_src_o, display_bcd_o); end
        step(0, 0, 0, 0, 1, 0, en);
        n_checks++; if ({display_src_o, display_bcd_o} !== {2'd2, 16'h0022}) begin n_fail++; $display("FAIL recall_second: got src %0d bcd %h expected src 2 bcd 0022", display_src_o, display_bcd_o); end
        step(0, 0, 0, 0, 1, 0, en);
        n_checks++; if ({dut.state_q, display_src_o, display_bcd_o} !== {2'd2, 2'd0, 16'h0777}) begin n_fail++; $display("FAIL recall_exit: got state %0d src %0d bcd %h expected 2 0 0777", dut.state_q, display_src_o, display_bcd_o); end
    endtask

    task automatic test_overflow();
        logic en;
        step(0, 0, 0, 0, 0, 1, en);
        step(0, 1, 0, 0, 0, 0, en);
        count_value_i = 16'h9999;
        step(1, 0, 0, 0, 0, 0, en);
        n_checks++; if (en !== 1'b0) begin n_fail++; $display("FAIL sat_enable: got %0b expected 0", en); end
        n_checks++; if ({overflow_o, dut.state_q} !== {1'b1, 2'd2}) begin n_fail++; $display("FAIL sat_pause: got ovf %0b state %0d expected 1 2", overflow_o, dut.state_q); end
        step(0, 1, 0, 0, 0, 0, en);
        n_checks++; if (dut.state_q !== 2'd2) begin n_fail++; $display("FAIL sat_start_blocked: got state %0d expected 2", dut.state_q); end
        step(0, 0, 0, 0, 0, 1, en);
        n_checks++; if ({dut.state_q, overflow_o, cnt_clear_o} !== {2'd0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL sat_clear: got state %0d ovf %0b clr %0b expected 0 0 1", dut.state_q, overflow_o, cnt_clear_o); end
        count_value_i = 16'h0000;
    endtask

    task automatic test_stop_beats_lap();
        logic en;
        step(0, 1, 0, 0, 0, 0, en);
        count_value_i = 16'h0050;
        step(0, 0, 1, 1, 0, 0, en);
        n_checks++; if ({lap_count_o, dut.state_q, display_src_o} !== {3'd0, 2'd2, 2'd0}) begin n_fail++; $display("FAIL stop_over_lap: got count %0d state %0d src %0d expected 0 2 0", lap_count_o, dut.state_q, display_src_o); end
    endtask

    task automatic test_back_to_back();
        logic en;
        step(0, 0, 0, 0, 0, 1, en);
        step(0, 1, 0, 0, 0, 0, en);
        count_value_i = 16'h0042; step(0, 0, 0, 1, 0, 0, en);
        count_value_i = 16'h0043; step(0, 0, 0, 1, 0, 0, en);
        n_checks++; if (lap_count_o !== 3'd2) begin n_fail++; $display("FAIL b2b_laps: got %0d expected 2", lap_count_o); end
        step(1, 1, 0, 0, 0, 1, en);
        n_checks++; if (en !== 1'b0) begin n_fail++; $display("FAIL b2b_clear_enable: got %0b expected 0", en); end
        n_checks++; if ({dut.state_q, cnt_clear_o, lap_count_o} !== {2'd0, 1'b1, 3'd0}) begin n_fail++; $display("FAIL b2b_clear: got state %0d clr %0b count %0d expected 0 1 0", dut.state_q, cnt_clear_o, lap_count_o); end
        step(1, 0, 0, 0, 0, 0, en);
        n_checks++; if ({en, cnt_clear_o} !== 2'b00) begin n_fail++; $display("FAIL b2b_after: got en %0b clr %0b expected 0 0", en, cnt_clear_o); end
    endtask

    initial begin
        test_reset();
        test_run_stop();
        test_lap_hold();
        test_lap_full();
        test_recall();
        test_overflow();
        test_stop_beats_lap();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
